// File: rtl/benes_cfg_loader.sv
// benes_cfg_loader: multi-context Benes switch config store with staged apply into output selects
module benes_cfg_loader #(
  parameter int STAGE_NUM = 9,
  parameter int SWITCH_NUM = 16,
  parameter int CTX_NUM = 4,
  localparam int CW = $clog2(CTX_NUM),
  localparam int SW = $clog2(STAGE_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [CW-1:0]         i_cfg_ctx,
  input  logic [SW-1:0]         i_cfg_stage,
  input  logic                  i_cfg_plane,
  input  logic [SWITCH_NUM-1:0] i_cfg_data,
  input  logic                  i_apply_valid,
  output logic                  o_apply_ready,
  input  logic [CW-1:0]         i_apply_ctx,
  output logic [SWITCH_NUM-1:0] o_module_select [0:STAGE_NUM-1],
  output logic [SWITCH_NUM-1:0] o_slot_select [0:STAGE_NUM-1],
  output logic                  o_cfg_stable,
  output logic [CW-1:0]         o_active_ctx,
  output logic                  o_apply_done,
  output logic                  o_apply_err,
  output logic                  o_cfg_err
);
  typedef enum logic {IDLE, APPLY} state_t;
  state_t state;
  logic [SWITCH_NUM-1:0] mem [CTX_NUM][2][STAGE_NUM];
  logic [STAGE_NUM-1:0] mask [CTX_NUM][2];
  logic [SW-1:0] k;
  logic [CW-1:0] lat_ctx;
  logic cfg_fire, stage_ok, wr, complete;
  assign o_cfg_ready = state == IDLE;
  assign o_apply_ready = state == IDLE;
  assign cfg_fire = i_cfg_valid && o_cfg_ready;
  assign stage_ok = i_cfg_stage < SW'(STAGE_NUM);
  assign wr = cfg_fire && stage_ok;
  assign complete = &mask[i_apply_ctx][0] && &mask[i_apply_ctx][1];
  always_ff @(posedge clk)
    if (wr) mem[i_cfg_ctx][i_cfg_plane][i_cfg_stage] <= i_cfg_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      lat_ctx <= '0;
      o_cfg_stable <= 1'b1;
      o_active_ctx <= '0;
      o_apply_done <= 1'b0;
      o_apply_err <= 1'b0;
      o_cfg_err <= 1'b0;
      for (int c = 0; c < CTX_NUM; c++) begin
        mask[c][0] <= '0;
        mask[c][1] <= '0;
      end
      for (int s = 0; s < STAGE_NUM; s++) begin
        o_module_select[s] <= '0;
        o_slot_select[s] <= '0;
      end
    end else begin
      o_apply_done <= 1'b0;
      o_apply_err <= state == IDLE && i_apply_valid && !complete;
      o_cfg_err <= cfg_fire && !stage_ok;
      if (wr) mask[i_cfg_ctx][i_cfg_plane][i_cfg_stage] <= 1'b1;
      if (state == IDLE) begin
        if (i_apply_valid && complete) begin
          state <= APPLY;
          lat_ctx <= i_apply_ctx;
          k <= '0;
          o_cfg_stable <= 1'b0;
        end
      end else begin
        o_module_select[k] <= mem[lat_ctx][0][k];
        o_slot_select[k] <= mem[lat_ctx][1][k];
        k <= k + 1'b1;
        if (k == SW'(STAGE_NUM - 1)) begin
          state <= IDLE;
          o_active_ctx <= lat_ctx;
          o_cfg_stable <= 1'b1;
          o_apply_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_benes_cfg_loader.sv
// tb_benes_cfg_loader: directed self-checking bench for benes_cfg_loader
module tb_benes_cfg_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0, cfg_plane = 1'b0, apply_valid = 1'b0;
  logic [1:0] cfg_ctx = '0, apply_ctx = '0;
  logic [3:0] cfg_stage = '0;
  logic [15:0] cfg_data = '0;
  logic cfg_ready, apply_ready, cfg_stable, apply_done, apply_err, cfg_err;
  logic [1:0] active_ctx;
  logic [15:0] module_sel [0:8];
  logic [15:0] slot_sel [0:8];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  benes_cfg_loader dut (
    .clk(clk), .rst(rst),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready), .i_cfg_ctx(cfg_ctx),
    .i_cfg_stage(cfg_stage), .i_cfg_plane(cfg_plane), .i_cfg_data(cfg_data),
    .i_apply_valid(apply_valid), .o_apply_ready(apply_ready), .i_apply_ctx(apply_ctx),
    .o_module_select(module_sel), .o_slot_select(slot_sel),
    .o_cfg_stable(cfg_stable), .o_active_ctx(active_ctx),
    .o_apply_done(apply_done), .o_apply_err(apply_err), .o_cfg_err(cfg_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] c, input logic p, input logic [3:0] s, input logic [15:0] d);
    cfg_valid = 1'b1;
    cfg_ctx = c;
    cfg_plane = p;
    cfg_stage = s;
    cfg_data = d;
    tick();
    cfg_valid = 1'b0;
  endtask
  task automatic load(input logic [1:0] c, input logic [15:0] mb, input logic [15:0] sb, input bit skip_s8);
    for (int s = 0; s < 9; s++) begin
      wr(c, 1'b0, 4'(s), mb + 16'(s));
      if (!(skip_s8 && s == 8)) wr(c, 1'b1, 4'(s), sb + 16'(s));
    end
  endtask
  task automatic apply(input logic [1:0] c);
    apply_valid = 1'b1;
    apply_ctx = c;
    tick();
    apply_valid = 1'b0;
  endtask
  task automatic check_all_zero(input string tag);
    logic [15:0] acc;
    acc = '0;
    for (int s = 0; s < 9; s++) acc |= module_sel[s] | slot_sel[s];
    check(tag, acc, 0);
  endtask
  initial begin
    int bad;
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("rst_sel");
    check("rst_stable", cfg_stable, 1);
    check("rst_active", active_ctx, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_apply_ready", apply_ready, 1);
    check("rst_done", apply_done, 0);
    load(2'd1, 16'hA300, 16'h00A8, 1'b0);
    apply(2'd1);
    bad = 0;
    for (int i = 1; i <= 9; i++) begin
      if (cfg_stable !== 1'b0 || apply_ready !== 1'b0 || apply_done !== 1'b0) bad++;
      tick();
    end
    check("apply1_busy_cycles", bad, 0);
    check("apply1_stable", cfg_stable, 1);
    check("apply1_done", apply_done, 1);
    check("apply1_active", active_ctx, 1);
    check("apply1_ready", apply_ready, 1);
    bad = 0;
    for (int s = 0; s < 9; s++)
      if (module_sel[s] !== 16'hA300 + 16'(s) || slot_sel[s] !== 16'h00A8 + 16'(s)) bad++;
    check("apply1_selects", bad, 0);
    tick();
    check("apply1_done_pulse", apply_done, 0);
    load(2'd2, 16'h2100, 16'h2200, 1'b1);
    apply(2'd2);
    check("incomplete_err", apply_err, 1);
    check("incomplete_stable", cfg_stable, 1);
    check("incomplete_ready", apply_ready, 1);
    check("incomplete_mod8", module_sel[8], 16'hA308);
    check("incomplete_active", active_ctx, 1);
    tick();
    check("incomplete_err_pulse", apply_err, 0);
    wr(2'd2, 1'b1, 4'd9, 16'hDEAD);
    check("stage9_err", cfg_err, 1);
    tick();
    check("stage9_err_pulse", cfg_err, 0);
    wr(2'd2, 1'b1, 4'd15, 16'hDEAD);
    check("stage15_err", cfg_err, 1);
    apply(2'd2);
    check("bad_stage_no_fill", apply_err, 1);
    load(2'd0, 16'h0C00, 16'h0D00, 1'b0);
    apply(2'd0);
    cfg_valid = 1'b1;
    cfg_ctx = 2'd3;
    cfg_plane = 1'b0;
    cfg_stage = 4'd0;
    cfg_data = 16'h1234;
    bad = 0;
    for (int i = 1; i <= 9; i++) begin
      if (cfg_ready !== 1'b0) bad++;
      tick();
    end
    check("busy_cfg_ready_low", bad, 0);
    check("busy_cfg_ready_back", cfg_ready, 1);
    check("apply0_done", apply_done, 1);
    check("apply0_mod3", module_sel[3], 16'h0C03);
    check("apply0_slot8", slot_sel[8], 16'h0D08);
    tick();
    cfg_valid = 1'b0;
    for (int s = 0; s < 9; s++) begin
      if (s != 0) wr(2'd3, 1'b0, 4'(s), 16'h3100 + 16'(s));
      wr(2'd3, 1'b1, 4'(s), 16'h3200 + 16'(s));
    end
    cfg_valid = 1'b1;
    cfg_ctx = 2'd3;
    cfg_plane = 1'b0;
    cfg_stage = 4'd4;
    cfg_data = 16'hBEEF;
    apply(2'd3);
    cfg_valid = 1'b0;
    check("wr_apply_accept", cfg_stable, 0);
    for (int i = 1; i <= 9; i++) tick();
    check("wr_apply_done", apply_done, 1);
    check("wr_apply_active", active_ctx, 3);
    check("held_word_mod0", module_sel[0], 16'h1234);
    check("same_cycle_mod4", module_sel[4], 16'hBEEF);
    check("wr_apply_slot8", slot_sel[8], 16'h3208);
    cfg_valid = 1'b1;
    cfg_ctx = 2'd2;
    cfg_plane = 1'b1;
    cfg_stage = 4'd8;
    cfg_data = 16'h2208;
    apply(2'd2);
    cfg_valid = 1'b0;
    check("old_mask_err", apply_err, 1);
    check("old_mask_stable", cfg_stable, 1);
    apply(2'd2);
    check("ctx2_accept", cfg_stable, 0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("abort_sel");
    check("abort_stable", cfg_stable, 1);
    check("abort_ready", apply_ready, 1);
    check("abort_active", active_ctx, 0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (apply_done !== 1'b0) bad++;
      tick();
    end
    check("abort_no_done", bad, 0);
    apply(2'd1);
    check("masks_cleared_err", apply_err, 1);
    check("masks_cleared_stable", cfg_stable, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
